dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Data-memory responder serving the MEM stage's load/store requests. Single-beat valid/ready request channel, one-cycle response pulse. Backed by four byte-lane synchronous RAM banks (little-endian) plus a memory-mapped I/O window (LED output register, switch input). Performs load lane extraction with sign/zero extension, and checks store byte-enables and alignment; the MEM stage no longer needs to format loads.

Parameters:
ADDR_W, 14, word-address width of each RAM bank; RAM window is byte addresses 0 .. 2^(ADDR_W+2)-1
LED_ADDR, 32'hFFFF_FC60, byte address of the LED register
SW_ADDR, 32'hFFFF_FC70, byte address of the switch input

Ports:
clk  input  1  system clock; all state on the rising edge
clrn  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request this cycle
req_addr  input  32  byte address
req_wdata  input  32  store data, already lane-positioned by the MEM stage
req_be  input  4  byte write enables; nonzero means store
req_rd  input  1  load request
req_ldtype  input  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; other codes are illegal
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  32  formatted load data; 0 for stores and errors
rsp_err  output  1  request rejected; valid only with rsp_valid
led_out  output  24  LED register
sw_in  input  24  switch levels, sampled directly

Behaviour:
- Reset is asynchronous, active-low (clrn), single clock clk. Reset values: state IDLE, req_ready 0 while clrn low and 1 in the first IDLE cycle, rsp_valid 0, rsp_rdata 0, rsp_err 0, led_out 0. RAM contents are not reset.
- Handshake: accept when req_valid and req_ready. req_ready = (state == IDLE). No response backpressure; the requester must take the rsp_valid pulse.
- FSM states and transitions:
  - IDLE: on accept, latch addr, be, ldtype, rd and wdata. Store or error goes to RESP. Legal RAM load goes to RDWAIT. Legal IO load goes to RESP.
  - RDWAIT: RAM address is applied on the accept edge; douta is valid the following edge. Go to RESP.
  - RESP: drive rsp_valid=1 for exactly one cycle with rdata/err, then go to IDLE.
- Latency from accept edge to rsp_valid high: store, IO load and error take 1 cycle; RAM load takes 2 cycles. Back-to-back throughput is one request per 2 or 3 cycles.
- The store write happens on the accept edge. Each bank wea = be[i] & legal. Bank i holds byte lane i, bits 8i+7:8i.
- Error conditions (all lead to no write, rdata 0, err 1):
  - be nonzero and req_rd both set.
  - Neither be nonzero nor req_rd set.
  - be not in {1111 with addr[1:0]=00; 0011 or 1100 with addr[0]=0 and the matching half; one-hot matching addr[1:0]}.
  - lw with addr[1:0]!=0.
  - lh/lhu with addr[0]!=0.
  - Illegal ldtype.
  - Address outside the RAM window and not equal to LED_ADDR or SW_ADDR.
- Load formatting:
  - lb/lbu select byte addr[1:0].
  - lh/lhu select the half given by addr[1].
  - Sign extension for lb/lh; zero extension for lbu/lhu.
- IO map:
  - LED_ADDR store: per-lane write of led_out lanes 0..2; lane 3 is ignored.
  - LED_ADDR load returns {8'b0, led_out}, then formatted.
  - SW_ADDR load returns {8'b0, sw_in} sampled at the accept edge.
  - SW_ADDR store is accepted and discarded, err=0.
- Reset mid-operation: the pending request is dropped with no response. A store already committed on the accept edge stays written.
- req_valid held in RDWAIT/RESP is ignored until IDLE.

Decomposition:
- Shared package holds:
  - ldtype codes LD_W, LD_B, LD_BU, LD_H, LD_HU.
  - FSM state encoding.
  - LED_ADDR and SW_ADDR defaults.
- One sub-module: dmem_load_fmt, combinational lane select and extension from (word, addr[1:0], ldtype). It is reusable by a later cache.
- The four byte banks are the existing ram0..ram3 IP, clocked by clk.

Test Plan:
- Store 32'h8899AABB with be=1111 at 0x10, then lw at 0x10 -> store rsp 1 cycle after accept with err=0; load rsp 2 cycles after accept with rdata=32'h8899AABB.
- After the previous test, lb at 0x13 -> 32'hFFFFFF88. lbu at 0x13 -> 32'h00000088. lh at 0x10 -> 32'hFFFFAABB. lhu at 0x12 -> 32'h00008899.
- Store be=0001 with wdata=32'h000000CC at 0x10, then lw at 0x10 -> 32'h8899AACC (other lanes untouched).
- lw at 0x12, store be=0110, ldtype=101, and address 0x0010_0000 -> each gives err=1 and rdata=0; a following lw at 0x10 shows memory unchanged.
- Store 32'h00123456 to LED_ADDR -> led_out=24'h123456. With sw_in=24'hABCDEF, lw at SW_ADDR -> 32'h00ABCDEF.
- Assert clrn low during RDWAIT -> rsp_valid never pulses, led_out=0, req_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: load type codes, FSM states, IO map.
// Pure definitions; no logic, no latency, no flow control.
// Imported by the responder top and its load formatter.
package dmem_responder_pkg;

    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_B  = 3'b001;
    localparam logic [2:0] LD_BU = 3'b010;
    localparam logic [2:0] LD_H  = 3'b011;
    localparam logic [2:0] LD_HU = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RDWAIT = 2'd1,
        RESP   = 2'd2
    } stateT;

    localparam logic [31:0] LED_ADDR_DEF = 32'hFFFF_FC60;
    localparam logic [31:0] SW_ADDR_DEF  = 32'hFFFF_FC70;

endpackage

// File: rtl/dmem_responder_bank.sv
// One byte-lane synchronous RAM bank, read-first, registered read data.
// Read data valid the edge after an enabled access; write on the enabled edge.
// No flow control; contents are not reset.
module dmem_bank #(
    parameter int ADDR_W = 14
) (
    input  logic              clka,
    input  logic              ena,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [7:0]        dina,
    output logic [7:0]        douta
);

    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) mem[addra] <= dina;
            douta <= mem[addra];
        end
    end

endmodule

// File: rtl/dmem_responder_load_fmt.sv
// Load formatter: lane select plus sign/zero extension of a 32-bit word.
// Purely combinational, zero latency; no flow control.
// Illegal load codes yield zero so callers can rely on a clean value.
module dmem_load_fmt
    import dmem_responder_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  ldtype,
    output logic [31:0] data
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel = word[8*off +: 8];
        halfSel = off[1] ? word[31:16] : word[15:0];
        data    = 32'd0;
        case (ldtype)
            LD_W:    data = word;
            LD_B:    data = {{24{byteSel[7]}}, byteSel};
            LD_BU:   data = {24'd0, byteSel};
            LD_H:    data = {{16{halfSel[15]}}, halfSel};
            LD_HU:   data = {16'd0, halfSel};
            default: data = 32'd0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-banked RAM plus LED/switch IO, with load formatting and store checks.
// Latency accept->rsp_valid: 1 cycle for store/IO/error, 2 cycles for RAM loads.
// req_ready low outside IDLE; responses have no backpressure.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          ADDR_W   = 14,
    parameter logic [31:0] LED_ADDR = LED_ADDR_DEF,
    parameter logic [31:0] SW_ADDR  = SW_ADDR_DEF
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    input  logic        req_rd,
    input  logic [2:0]  req_ldtype,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [23:0] led_out,
    input  logic [23:0] sw_in
);

    stateT state, stateNext;

    logic accept, isStore, isLoad, inRam, isLed, isSw, beOk, ldOk, reqErr;
    logic [3:0]        ramWe;
    logic [ADDR_W-1:0] ramAddr;
    logic [31:0]       ramWord, fmtWord, fmtData;

    logic [1:0]  addrLoQ;
    logic [2:0]  ldQ;
    logic        rdQ, errQ, ioQ;
    logic [23:0] ioWordQ;

    assign req_ready = (state == IDLE) & clrn;
    assign accept    = req_valid & req_ready;
    assign isStore   = |req_be;
    assign isLoad    = req_rd;
    assign inRam     = (req_addr >> (ADDR_W + 2)) == 32'd0;
    assign isLed     = req_addr == LED_ADDR;
    assign isSw      = req_addr == SW_ADDR;

    // Half stores must sit in the half that addr[1] names; byte stores must match addr[1:0].
    assign beOk = (req_be == 4'b1111 && req_addr[1:0] == 2'b00)
               || (req_be == 4'b0011 && req_addr[1:0] == 2'b00)
               || (req_be == 4'b1100 && req_addr[1:0] == 2'b10)
               || (req_be == (4'b0001 << req_addr[1:0]));

    always_comb begin
        ldOk = 1'b0;
        case (req_ldtype)
            LD_W:        ldOk = req_addr[1:0] == 2'b00;
            LD_B, LD_BU: ldOk = 1'b1;
            LD_H, LD_HU: ldOk = ~req_addr[0];
            default:     ldOk = 1'b0;
        endcase
    end

    assign reqErr = (isStore && isLoad) || (!isStore && !isLoad)
                 || (isStore && !beOk) || (isLoad && !ldOk)
                 || !(inRam || isLed || isSw);

    assign ramWe   = (accept && !reqErr && isStore && inRam) ? req_be : 4'b0000;
    assign ramAddr = req_addr[ADDR_W+1:2];

    dmem_bank #(.ADDR_W(ADDR_W)) ram0 (.clka(clk), .ena(accept), .wea(ramWe[0]), .addra(ramAddr),
                                       .dina(req_wdata[7:0]),   .douta(ramWord[7:0]));
    dmem_bank #(.ADDR_W(ADDR_W)) ram1 (.clka(clk), .ena(accept), .wea(ramWe[1]), .addra(ramAddr),
                                       .dina(req_wdata[15:8]),  .douta(ramWord[15:8]));
    dmem_bank #(.ADDR_W(ADDR_W)) ram2 (.clka(clk), .ena(accept), .wea(ramWe[2]), .addra(ramAddr),
                                       .dina(req_wdata[23:16]), .douta(ramWord[23:16]));
    dmem_bank #(.ADDR_W(ADDR_W)) ram3 (.clka(clk), .ena(accept), .wea(ramWe[3]), .addra(ramAddr),
                                       .dina(req_wdata[31:24]), .douta(ramWord[31:24]));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (reqErr || isStore || !inRam) stateNext = RESP;
                    else                             stateNext = RDWAIT;
                end
            end
            RDWAIT:  stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            addrLoQ <= 2'b00;
            ldQ     <= LD_W;
            rdQ     <= 1'b0;
            errQ    <= 1'b0;
            ioQ     <= 1'b0;
            ioWordQ <= 24'd0;
            led_out <= 24'd0;
        end else if (accept) begin
            addrLoQ <= req_addr[1:0];
            ldQ     <= req_ldtype;
            rdQ     <= req_rd;
            errQ    <= reqErr;
            ioQ     <= isLed || isSw;
            ioWordQ <= isSw ? sw_in : led_out;
            if (!reqErr && isStore && isLed) begin
                for (int i = 0; i < 3; i++) begin
                    if (req_be[i]) led_out[8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // RAM read data holds through RESP because the banks are only enabled on accept.
    assign fmtWord = ioQ ? {8'd0, ioWordQ} : ramWord;

    dmem_load_fmt u_fmt (
        .word   (fmtWord),
        .off    (addrLoQ),
        .ldtype (ldQ),
        .data   (fmtData)
    );

    assign rsp_valid = state == RESP;
    assign rsp_err   = (state == RESP) && errQ;
    assign rsp_rdata = (state == RESP && rdQ && !errQ) ? fmtData : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        clrn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        req_rd;
    logic [2:0]  req_ldtype;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [23:0] led_out;
    logic [23:0] sw_in;

    int tests = 0;
    int fails = 0;

    localparam logic [31:0] LED_A = 32'hFFFF_FC60;
    localparam logic [31:0] SW_A  = 32'hFFFF_FC70;

    always #5 clk = ~clk;

    dmem_responder dut (
        .clk        (clk),
        .clrn       (clrn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .req_rd     (req_rd),
        .req_ldtype (req_ldtype),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .led_out    (led_out),
        .sw_in      (sw_in)
    );

    // Issues one request and waits (bounded) for its response; lat = -1 on timeout.
    task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                          input logic rd, input logic [2:0] ld,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output logic rdyMid);
        int waitCnt;
        rdata = 32'hDEAD_BEEF;
        err   = 1'bx;
        lat   = -1;
        rdyMid = 1'bx;
        @(negedge clk);
        waitCnt = 0;
        while (!req_ready && waitCnt < 10) begin
            @(negedge clk);
            waitCnt++;
        end
        req_addr   = addr;
        req_wdata  = wdata;
        req_be     = be;
        req_rd     = rd;
        req_ldtype = ld;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_be    = 4'b0000;
        req_rd    = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (n == 1) rdyMid = req_ready;
            if (rsp_valid) begin
                rdata = rsp_rdata;
                err   = rsp_err;
                lat   = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", req_ready); end
        tests++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin
            fails++; $display("FAIL reset_rsp got v=%b e=%b d=%h want 0/0/0", rsp_valid, rsp_err, rsp_rdata);
        end
        tests++;
        if (led_out !== 24'd0) begin fails++; $display("FAIL reset_led got %h want 000000", led_out); end
        clrn = 1'b1;
        #1;
        tests++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_idle_ready got %b want 1", req_ready); end
    endtask

    task automatic test_store_load();
        logic [31:0] d; logic e; int lat; logic rm;
        do_req(32'h10, 32'h8899AABB, 4'b1111, 1'b0, 3'b000, d, e, lat, rm);
        tests++;
        if (lat !== 1 || e !== 1'b0 || d !== 32'd0) begin
            fails++; $display("FAIL store_word got lat=%0d e=%b d=%h want 1/0/0", lat, e, d);
        end
        do_req(32'h10, 32'h0, 4'b0000, 1'b1, 3'b000, d, e, lat, rm);
        tests++;
        if (lat !== 2 || e !== 1'b0 || d !== 32'h8899AABB) begin
            fails++; $display("FAIL load_word got lat=%0d e=%b d=%h want 2/0/8899aabb", lat, e, d);
        end
        tests++;
        if (rm !== 1'b0) begin fails++; $display("FAIL ready_in_rdwait got %b want 0", rm); end
    endtask

    task automatic test_formats();
        logic [31:0] addrs [4] = '{32'h13, 32'h13, 32'h10, 32'h12};
        logic [2:0]  lds   [4] = '{3'b001, 3'b010, 3'b011, 3'b100};
        logic [31:0] exps  [4] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFFAABB, 32'h00008899};
        logic [31:0] d; logic e; int lat; logic rm;
        for (int i = 0; i < 4; i++) begin
            do_req(addrs[i], 32'h0, 4'b0000, 1'b1, lds[i], d, e, lat, rm);
            tests++;
            if (lat !== 2 || e !== 1'b0 || d !== exps[i]) begin
                fails++; $display("FAIL fmt_%0d got lat=%0d e=%b d=%h want 2/0/%h", i, lat, e, d, exps[i]);
            end
        end
    endtask

    task automatic test_partial_store();
        logic [31:0] d; logic e; int lat; logic rm;
        do_req(32'h10, 32'h000000CC, 4'b0001, 1'b0, 3'b000, d, e, lat, rm);
        tests++;
        if (lat !== 1 || e !== 1'b0) begin fails++; $display("FAIL store_byte got lat=%0d e=%b want 1/0", lat, e); end
        do_req(32'h10, 32'h0, 4'b0000, 1'b1, 3'b000, d, e, lat, rm);
        tests++;
        if (d !== 32'h8899AACC) begin fails++; $display("FAIL partial_readback got %h want 8899aacc", d); end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [4] = '{32'h12, 32'h10, 32'h10, 32'h0010_0000};
        logic [3:0]  bes   [4] = '{4'b0000, 4'b0110, 4'b0000, 4'b0000};
        logic        rds   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [2:0]  lds   [4] = '{3'b000, 3'b000, 3'b101, 3'b000};
        logic [31:0] d; logic e; int lat; logic rm;
        for (int i = 0; i < 4; i++) begin
            do_req(addrs[i], 32'hFFFFFFFF, bes[i], rds[i], lds[i], d, e, lat, rm);
            tests++;
            if (lat !== 1 || e !== 1'b1 || d !== 32'd0) begin
                fails++; $display("FAIL err_%0d got lat=%0d e=%b d=%h want 1/1/0", i, lat, e, d);
            end
        end
        do_req(32'h10, 32'h0, 4'b0000, 1'b1, 3'b000, d, e, lat, rm);
        tests++;
        if (d !== 32'h8899AACC || e !== 1'b0) begin
            fails++; $display("FAIL err_no_write got e=%b d=%h want 0/8899aacc", e, d);
        end
    endtask

    task automatic test_io();
        logic [31:0] d; logic e; int lat; logic rm;
        do_req(LED_A, 32'h00123456, 4'b1111, 1'b0, 3'b000, d, e, lat, rm);
        tests++;
        if (led_out !== 24'h123456 || e !== 1'b0 || lat !== 1) begin
            fails++; $display("FAIL led_store got led=%h e=%b lat=%0d want 123456/0/1", led_out, e, lat);
        end
        sw_in = 24'hABCDEF;
        do_req(SW_A, 32'h0, 4'b0000, 1'b1, 3'b000, d, e, lat, rm);
        tests++;
        if (d !== 32'h00ABCDEF || e !== 1'b0 || lat !== 1) begin
            fails++; $display("FAIL sw_load got d=%h e=%b lat=%0d want 00abcdef/0/1", d, e, lat);
        end
        do_req(LED_A, 32'h0, 4'b0000, 1'b1, 3'b001, d, e, lat, rm);
        tests++;
        if (d !== 32'h00000056) begin fails++; $display("FAIL led_lb got %h want 00000056", d); end
        do_req(SW_A, 32'h11111111, 4'b1111, 1'b0, 3'b000, d, e, lat, rm);
        tests++;
        if (e !== 1'b0 || d !== 32'd0 || led_out !== 24'h123456) begin
            fails++; $display("FAIL sw_store got e=%b d=%h led=%h want 0/0/123456", e, d, led_out);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        @(negedge clk);
        req_addr   = 32'h10;
        req_be     = 4'b0000;
        req_rd     = 1'b1;
        req_ldtype = 3'b000;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_rd    = 1'b0;
        clrn      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        tests++;
        if (led_out !== 24'd0) begin fails++; $display("FAIL midreset_led got %h want 000000", led_out); end
        clrn = 1'b1;
        #1;
        tests++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL midreset_ready got %b want 1", req_ready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        tests++;
        if (pulses !== 0) begin fails++; $display("FAIL midreset_rsp got %0d pulses want 0", pulses); end
    endtask

    initial begin
        clrn       = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_be     = 4'b0000;
        req_rd     = 1'b0;
        req_ldtype = 3'b000;
        sw_in      = 24'h5A5A5A;
        test_reset();
        test_store_load();
        test_formats();
        test_partial_store();
        test_errors();
        test_io();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
